// File: rtl/cook_timer_ctrl.sv
// ---------------------------------------------------------------------------
// cook_timer_ctrl
//
// Purpose:
//   Countdown cooking timer controller. Holds an MM:SS time in BCD, lets the
//   user dial it up with the increment buttons, counts it down once per
//   timer second while running, supports pause/resume without losing the
//   sub-second phase, and raises an alarm when the time reaches 00:00.
//   All outputs are registered.
//
// Parameters:
//   CLKS_PER_SEC  clk cycles per timer second (must be >= 2)
//   ALARM_SECS    alarm auto-clear time in seconds (timeout build only)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_p      in   synchronous, active-high reset
//   btn_start    in   one-cycle pulse: start/pause toggle, alarm acknowledge
//   btn_clear    in   one-cycle pulse: abort to IDLE
//   btn_inc_min  in   one-cycle pulse: minutes +1 (IDLE/SET only)
//   btn_inc_sec  in   one-cycle pulse: seconds +1 (IDLE/SET only)
//   min10..sec1  out  BCD time digits
//   state        out  IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4
//   running      out  high in RUN
//   alarm        out  high in ALARM
//   done_pulse   out  one cycle on entering ALARM
//
// Build option:
//   COOK_TIMER_ALARM_TIMEOUT_EN  when defined, ALARM clears itself back to
//                                IDLE after ALARM_SECS timer seconds.
// ---------------------------------------------------------------------------
module cook_timer_ctrl #(
    parameter int CLKS_PER_SEC = 100_000_000,
    parameter int ALARM_SECS   = 10
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_inc_min,
    input  logic       btn_inc_sec,
    output logic [3:0] min10,
    output logic [3:0] min1,
    output logic [3:0] sec10,
    output logic [3:0] sec1,
    output logic [2:0] state,
    output logic       running,
    output logic       alarm,
    output logic       done_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_SEC - 1);

    // Reject parameter values the prescaler and alarm timeout cannot honour.
    generate
        if (CLKS_PER_SEC < 2 || ALARM_SECS < 1) begin : g_badParams
            $error("cook_timer_ctrl: needs CLKS_PER_SEC >= 2 and ALARM_SECS >= 1");
        end
    endgenerate

    state_t        r_state;
    state_t        w_nextState;
    logic [3:0]    r_min10, r_min1, r_sec10, r_sec1;
    logic [3:0]    w_min10Next, w_min1Next, w_sec10Next, w_sec1Next;
    logic [3:0]    w_incMin10, w_incMin1, w_incSec10, w_incSec1;
    logic [3:0]    w_decMin10, w_decMin1, w_decSec10, w_decSec1;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_prescNext;
    logic          r_running, r_alarm, r_done;
    logic          w_timeZero, w_decZero, w_secTick;

`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
    localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);
    logic [AW-1:0] r_alarmCnt;
    logic [AW-1:0] w_alarmCntNext;
`endif

    assign w_timeZero = (r_min10 == 4'd0) && (r_min1 == 4'd0) &&
                        (r_sec10 == 4'd0) && (r_sec1 == 4'd0);
    assign w_secTick  = (r_presc == PRESC_MAX);
    assign w_decZero  = (w_decMin10 == 4'd0) && (w_decMin1 == 4'd0) &&
                        (w_decSec10 == 4'd0) && (w_decSec1 == 4'd0);

    // Increment values for the set buttons. Seconds wrap 59->00 on their
    // own; there is deliberately no carry into the minutes.
    always_comb begin
        w_incSec1  = (r_sec1 == 4'd9) ? 4'd0 : r_sec1 + 4'd1;
        w_incSec10 = r_sec10;
        if (r_sec1 == 4'd9) begin
            w_incSec10 = (r_sec10 == 4'd5) ? 4'd0 : r_sec10 + 4'd1;
        end
        w_incMin1  = (r_min1 == 4'd9) ? 4'd0 : r_min1 + 4'd1;
        w_incMin10 = r_min10;
        if (r_min1 == 4'd9) begin
            w_incMin10 = (r_min10 == 4'd5) ? 4'd0 : r_min10 + 4'd1;
        end
    end

    // One-second BCD decrement with borrow chain sec1 -> sec10 -> min1 ->
    // min10. At 00:00 the value is held so the time can never underflow.
    always_comb begin
        w_decMin10 = r_min10;
        w_decMin1  = r_min1;
        w_decSec10 = r_sec10;
        w_decSec1  = r_sec1;
        if (!w_timeZero) begin
            if (r_sec1 != 4'd0) begin
                w_decSec1 = r_sec1 - 4'd1;
            end else begin
                w_decSec1 = 4'd9;
                if (r_sec10 != 4'd0) begin
                    w_decSec10 = r_sec10 - 4'd1;
                end else begin
                    w_decSec10 = 4'd5;
                    if (r_min1 != 4'd0) begin
                        w_decMin1 = r_min1 - 4'd1;
                    end else begin
                        w_decMin1  = 4'd9;
                        w_decMin10 = r_min10 - 4'd1;
                    end
                end
            end
        end
    end

    // Next-state and next-data logic. Button priority is clear > start > inc.
    // In RUN the prescaler and the decrement advance on every edge, even the
    // one that also sees start or clear; that is what keeps the sub-second
    // phase intact across a pause and makes a start on the final tick land
    // in PAUSE at 00:00.
    always_comb begin
        w_nextState = r_state;
        w_min10Next = r_min10;
        w_min1Next  = r_min1;
        w_sec10Next = r_sec10;
        w_sec1Next  = r_sec1;
        w_prescNext = r_presc;
`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
        w_alarmCntNext = '0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_prescNext = '0;
                if (!btn_clear && !btn_start && (btn_inc_min || btn_inc_sec)) begin
                    w_nextState = ST_SET;
                    if (btn_inc_min) begin
                        w_min10Next = w_incMin10;
                        w_min1Next  = w_incMin1;
                    end
                    if (btn_inc_sec) begin
                        w_sec10Next = w_incSec10;
                        w_sec1Next  = w_incSec1;
                    end
                end
            end
            ST_SET: begin
                if (btn_clear) begin
                    w_nextState = ST_IDLE;
                    w_min10Next = 4'd0;
                    w_min1Next  = 4'd0;
                    w_sec10Next = 4'd0;
                    w_sec1Next  = 4'd0;
                end else if (btn_start) begin
                    w_nextState = w_timeZero ? ST_IDLE : ST_RUN;
                    w_prescNext = '0;
                end else begin
                    if (btn_inc_min) begin
                        w_min10Next = w_incMin10;
                        w_min1Next  = w_incMin1;
                    end
                    if (btn_inc_sec) begin
                        w_sec10Next = w_incSec10;
                        w_sec1Next  = w_incSec1;
                    end
                end
            end
            ST_RUN: begin
                w_prescNext = w_secTick ? '0 : r_presc + PW'(1);
                if (w_secTick) begin
                    w_min10Next = w_decMin10;
                    w_min1Next  = w_decMin1;
                    w_sec10Next = w_decSec10;
                    w_sec1Next  = w_decSec1;
                end
                if (btn_clear) begin
                    w_nextState = ST_IDLE;
                    w_min10Next = 4'd0;
                    w_min1Next  = 4'd0;
                    w_sec10Next = 4'd0;
                    w_sec1Next  = 4'd0;
                    w_prescNext = '0;
                end else if (btn_start) begin
                    w_nextState = ST_PAUSE;
                end else if (w_secTick && w_decZero) begin
                    w_nextState = ST_ALARM;
                end
            end
            ST_PAUSE: begin
                if (btn_clear) begin
                    w_nextState = ST_IDLE;
                    w_min10Next = 4'd0;
                    w_min1Next  = 4'd0;
                    w_sec10Next = 4'd0;
                    w_sec1Next  = 4'd0;
                    w_prescNext = '0;
                end else if (btn_start) begin
                    // Paused exactly on the final tick: resuming means alarm.
                    if (w_timeZero) begin
                        w_nextState = ST_ALARM;
                        w_prescNext = '0;
                    end else begin
                        w_nextState = ST_RUN;
                    end
                end
            end
            ST_ALARM: begin
                w_min10Next = 4'd0;
                w_min1Next  = 4'd0;
                w_sec10Next = 4'd0;
                w_sec1Next  = 4'd0;
                if (btn_clear || btn_start) begin
                    w_nextState = ST_IDLE;
                    w_prescNext = '0;
                end else begin
`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
                    w_prescNext    = w_secTick ? '0 : r_presc + PW'(1);
                    w_alarmCntNext = r_alarmCnt;
                    if (w_secTick) begin
                        if (r_alarmCnt == ALARM_LAST) begin
                            w_nextState    = ST_IDLE;
                            w_alarmCntNext = '0;
                        end else begin
                            w_alarmCntNext = r_alarmCnt + AW'(1);
                        end
                    end
`endif
                end
            end
            default: begin
                w_nextState = ST_IDLE;
                w_min10Next = 4'd0;
                w_min1Next  = 4'd0;
                w_sec10Next = 4'd0;
                w_sec1Next  = 4'd0;
                w_prescNext = '0;
            end
        endcase
    end

    // State and data registers. The status flags are decoded from the next
    // state so they line up with the registered state output; done_pulse
    // fires only on the transition into ALARM.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state   <= ST_IDLE;
            r_min10   <= 4'd0;
            r_min1    <= 4'd0;
            r_sec10   <= 4'd0;
            r_sec1    <= 4'd0;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_alarm   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_min10   <= w_min10Next;
            r_min1    <= w_min1Next;
            r_sec10   <= w_sec10Next;
            r_sec1    <= w_sec1Next;
            r_presc   <= w_prescNext;
            r_running <= (w_nextState == ST_RUN);
            r_alarm   <= (w_nextState == ST_ALARM);
            r_done    <= (w_nextState == ST_ALARM) && (r_state != ST_ALARM);
        end
    end

`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
    // Seconds spent in ALARM, used for the automatic return to IDLE.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_alarmCnt <= '0;
        end else begin
            r_alarmCnt <= w_alarmCntNext;
        end
    end
`endif

    assign min10      = r_min10;
    assign min1       = r_min1;
    assign sec10      = r_sec10;
    assign sec1       = r_sec1;
    assign state      = r_state;
    assign running    = r_running;
    assign alarm      = r_alarm;
    assign done_pulse = r_done;

endmodule
